// File: rtl/echo_request_serializer_pkg.sv
// Shared constants, state encoding and header helper for the echo request
// serializer and its message FIFO.
package echo_request_serializer_pkg;

  localparam int MSG_WIDTH  = 160;
  localparam int WORD_WIDTH = 32;

  localparam logic [WORD_WIDTH-1:0] TAG_SAY  = 32'd1;
  localparam logic [WORD_WIDTH-1:0] TAG_SAY2 = 32'd2;

  // Total beats per message, header included; carried in the header's low half.
  localparam logic [15:0] BEAT_COUNT = 16'd3;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY0 = 2'd1,
    S_PAY1 = 2'd2
  } state_t;

  function automatic logic [WORD_WIDTH-1:0] make_header(input logic [15:0] tag);
    return {tag, BEAT_COUNT};
  endfunction

endpackage

// File: rtl/echo_request_serializer_if.sv
// Request-in / beat-out handshake bundle plus the message and drop counters.
interface echo_request_serializer_if;
  import echo_request_serializer_pkg::*;

  // ENA/RDY methods: ENA is raised only while RDY is high, and a transfer
  // happens on every rising clock edge where ENA is high.
  logic                  pipe_enq__ENA;
  logic [MSG_WIDTH-1:0]  pipe_enq_v;
  logic                  pipe_enq__RDY;
  logic                  out_enq__ENA;
  logic [WORD_WIDTH-1:0] out_enq_v;
  logic                  out_enq__RDY;
  logic [15:0]           count_msgs;
  logic [15:0]           count_drops;

  modport master (
    output pipe_enq__ENA, pipe_enq_v, out_enq__RDY,
    input  pipe_enq__RDY, out_enq__ENA, out_enq_v, count_msgs, count_drops
  );

  modport slave (
    input  pipe_enq__ENA, pipe_enq_v, out_enq__RDY,
    output pipe_enq__RDY, out_enq__ENA, out_enq_v, count_msgs, count_drops
  );

endinterface

// File: rtl/echo_request_serializer_msg_fifo2.sv
// Two-entry FIFO; slot0 is always the head so the consumer reads it directly.
module msg_fifo2 #(
  parameter int WIDTH = 160
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (cnt != 2'd2);
  assign do_pop  = pop  && (cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
    end else begin
      // With one entry, a simultaneous pop lets the incoming message land at the head.
      if (do_push && ((cnt == 2'd0) || ((cnt == 2'd1) && do_pop)))
        slot0 <= din;
      else if (do_pop)
        slot0 <= slot1;

      if (do_push && (cnt == 2'd1) && !do_pop)
        slot1 <= din;

      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = slot0;
  assign count = cnt;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/echo_request_serializer.sv
// Buffers 160-bit echo requests and emits each as header + two payload beats;
// unknown tags are dropped at the head of the FIFO and counted.
module echo_request_serializer
  import echo_request_serializer_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST,
  echo_request_serializer_if.slave   bus,
  output state_t                     state
);

  logic [MSG_WIDTH-1:0]  head;
  logic [1:0]            fifo_count;
  logic                  fifo_full_unused;
  logic                  empty;
  logic                  pop;
  logic [WORD_WIDTH-1:0] w0, w1, w2, w3, w4;
  logic                  is_known;
  logic                  is_say2;
  logic                  beat_avail;
  logic [WORD_WIDTH-1:0] beat;
  logic [15:0]           msgs_q;
  logic [15:0]           drops_q;

  msg_fifo2 #(.WIDTH(MSG_WIDTH)) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (bus.pipe_enq__ENA),
    .din   (bus.pipe_enq_v),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full_unused),
    .empty (empty)
  );

  // Admission looks only at the current occupancy, never at a same-cycle pop.
  assign bus.pipe_enq__RDY = (fifo_count < 2'd2);

  always_comb begin
    w0 = head[31:0];
    w1 = head[63:32];
    w2 = head[95:64];
    w3 = head[127:96];
    w4 = head[159:128];

    is_known   = !empty && ((w0 == TAG_SAY) || (w0 == TAG_SAY2));
    is_say2    = (w0 == TAG_SAY2);
    beat_avail = (state != S_HDR) || is_known;

    beat = '0;
    case (state)
      S_HDR:   beat = make_header(w0[15:0]);
      S_PAY0:  beat = is_say2 ? w3 : w1;
      S_PAY1:  beat = is_say2 ? w4 : w2;
      default: beat = '0;
    endcase

    bus.out_enq__ENA = beat_avail && bus.out_enq__RDY;
    bus.out_enq_v    = beat_avail ? beat : '0;

    pop = ((state == S_HDR) && !empty && !is_known) ||
          ((state == S_PAY1) && bus.out_enq__RDY);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_HDR;
      msgs_q  <= 16'd0;
      drops_q <= 16'd0;
    end else begin
      case (state)
        S_HDR: begin
          if (!empty && !is_known)
            drops_q <= drops_q + 16'd1;
          else if (is_known && bus.out_enq__RDY)
            state <= S_PAY0;
        end
        S_PAY0: begin
          if (bus.out_enq__RDY)
            state <= S_PAY1;
        end
        S_PAY1: begin
          if (bus.out_enq__RDY) begin
            state  <= S_HDR;
            msgs_q <= msgs_q + 16'd1;
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

  assign bus.count_msgs  = msgs_q;
  assign bus.count_drops = drops_q;

endmodule

// File: tb/tb_echo_request_serializer.sv
// Directed bench for echo_request_serializer: vector table plus stall, reset and wrap sequences.
module tb_echo_request_serializer;
  import echo_request_serializer_pkg::*;

  logic   clk;
  logic   rst;
  state_t dut_state;

  echo_request_serializer_if bus ();

  echo_request_serializer dut (
    .CLK   (clk),
    .RST   (rst),
    .bus   (bus.slave),
    .state (dut_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [15:0] exp_msgs;
  logic [15:0] exp_drops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/empty expected event", name);
  endtask

  // The beat port must stay quiet whenever the consumer is not ready.
  always @(negedge clk) begin
    if (!rst && !bus.out_enq__RDY) begin
      total++;
      if (bus.out_enq__ENA !== 1'b0) begin
        bad++;
        $display("FAIL proto_ena_without_rdy: got %b expected 0", bus.out_enq__ENA);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [159:0] pack(input logic [31:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input logic [159:0] m);
    int guard = 0;
    while (!bus.pipe_enq__RDY && guard < 20) begin
      tick();
      guard++;
    end
    if (guard == 20) fail_now("push_wait_rdy");
    bus.pipe_enq_v    = m;
    bus.pipe_enq__ENA = 1'b1;
    tick();
    bus.pipe_enq__ENA = 1'b0;
  endtask

  task automatic expect_beats(input string name, input int n);
    logic [31:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("%s_ena%0d", name, k), {31'd0, bus.out_enq__ENA}, 32'd1);
      if (exp_q.size() == 0) begin
        fail_now($sformatf("%s_expq%0d", name, k));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_beat%0d", name, k), bus.out_enq_v, e);
      end
      tick();
    end
  endtask

  task automatic check_counters(input string name);
    check({name, "_msgs"},  {16'd0, bus.count_msgs},  {16'd0, exp_msgs});
    check({name, "_drops"}, {16'd0, bus.count_drops}, {16'd0, exp_drops});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] w0, w1, w2, w3, w4;
    logic        known;
    logic [31:0] b0, b1, b2;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input string nm, input logic [31:0] a0, a1, a2, a3, a4,
                              input logic kn, input logic [31:0] e0, e1, e2);
    vec_t v;
    v.name = nm; v.w0 = a0; v.w1 = a1; v.w2 = a2; v.w3 = a3; v.w4 = a4;
    v.known = kn; v.b0 = e0; v.b1 = e1; v.b2 = e2;
    return v;
  endfunction

  initial begin
    vecs[0] = mk("say_basic", 32'd1, 32'hA, 32'hB, 32'h0, 32'h0, 1'b1,
                 32'h0001_0003, 32'h0000_000A, 32'h0000_000B);
    vecs[1] = mk("say2_basic", 32'd2, 32'hDEAD, 32'hBEEF, 32'h11, 32'h22, 1'b1,
                 32'h0002_0003, 32'h0000_0011, 32'h0000_0022);
    vecs[2] = mk("drop_tag7", 32'd7, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 32'h0, 32'h0, 32'h0);
    vecs[3] = mk("say_ignore_w34", 32'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h5555_5555,
                 32'h6666_6666, 1'b1, 32'h0001_0003, 32'h1234_5678, 32'h9ABC_DEF0);
    vecs[4] = mk("drop_tag0", 32'd0, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 32'h0, 32'h0, 32'h0);
    vecs[5] = mk("drop_tag_hi", 32'h0001_0001, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0,
                 32'h0, 32'h0, 32'h0);
    vecs[6] = mk("say2_extremes", 32'd2, 32'h7, 32'h8, 32'hFFFF_FFFF, 32'h0, 1'b1,
                 32'h0002_0003, 32'hFFFF_FFFF, 32'h0000_0000);
    vecs[7] = mk("drop_tag3", 32'd3, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 32'h0, 32'h0, 32'h0);
  end

  // ---------------- main sequence ----------------
  initial begin
    int pushes;
    int cycles;

    rst = 1'b1;
    bus.pipe_enq__ENA = 1'b0;
    bus.pipe_enq_v    = '0;
    bus.out_enq__RDY  = 1'b1;
    exp_msgs  = 16'd0;
    exp_drops = 16'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pipe_rdy", {31'd0, bus.pipe_enq__RDY}, 32'd1);
    check("rst_out_ena",  {31'd0, bus.out_enq__ENA}, 32'd0);
    check("rst_out_v",    bus.out_enq_v, 32'd0);
    check("rst_state",    {30'd0, dut_state}, {30'd0, S_HDR});
    check_counters("rst");
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      push_msg(pack(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3, vecs[i].w4));
      if (vecs[i].known) begin
        exp_q.push_back(vecs[i].b0);
        exp_q.push_back(vecs[i].b1);
        exp_q.push_back(vecs[i].b2);
        expect_beats(vecs[i].name, 3);
        exp_msgs++;
      end else begin
        @(negedge clk);
        check({vecs[i].name, "_noena"}, {31'd0, bus.out_enq__ENA}, 32'd0);
        tick();
        exp_drops++;
      end
      check_counters(vecs[i].name);
    end

    // Drop followed immediately by a say: push and pop coincide at count 1.
    push_msg(pack(32'd7, 32'h1, 32'h2, 32'h3, 32'h4));
    bus.pipe_enq_v    = pack(32'd1, 32'hC1, 32'hC2, 32'h0, 32'h0);
    bus.pipe_enq__ENA = 1'b1;
    @(negedge clk);
    check("drop_then_say_noena", {31'd0, bus.out_enq__ENA}, 32'd0);
    check("drop_then_say_pre",   {16'd0, bus.count_drops}, {16'd0, exp_drops});
    tick();
    bus.pipe_enq__ENA = 1'b0;
    exp_drops++;
    check("drop_then_say_post", {16'd0, bus.count_drops}, {16'd0, exp_drops});
    exp_q.push_back(32'h0001_0003);
    exp_q.push_back(32'hC1);
    exp_q.push_back(32'hC2);
    expect_beats("drop_then_say", 3);
    exp_msgs++;
    check_counters("drop_then_say");

    // Stall three cycles in PAY0 while the FIFO fills, then drain back-to-back.
    push_msg(pack(32'd2, 32'hEE, 32'hEF, 32'h55, 32'h66));
    exp_q.push_back(32'h0002_0003);
    expect_beats("stall_hdr", 1);
    bus.out_enq__RDY  = 1'b0;
    bus.pipe_enq_v    = pack(32'd1, 32'h77, 32'h88, 32'h0, 32'h0);
    bus.pipe_enq__ENA = 1'b1;
    @(negedge clk);
    check("stall_state_pay0", {30'd0, dut_state}, {30'd0, S_PAY0});
    tick();
    bus.pipe_enq__ENA = 1'b0;
    for (int s = 1; s < 3; s++) begin
      @(negedge clk);
      check($sformatf("stall_full%0d", s), {31'd0, bus.pipe_enq__RDY}, 32'd0);
      check($sformatf("stall_state%0d", s), {30'd0, dut_state}, {30'd0, S_PAY0});
      tick();
    end
    bus.out_enq__RDY = 1'b1;
    exp_q.push_back(32'h55);
    exp_q.push_back(32'h66);
    exp_q.push_back(32'h0001_0003);
    exp_q.push_back(32'h77);
    exp_q.push_back(32'h88);
    expect_beats("stall_resume", 5);
    exp_msgs += 16'd2;
    check_counters("stall");
    check("stall_rdy_back", {31'd0, bus.pipe_enq__RDY}, 32'd1);

    // Reset in PAY1 abandons the message without counting it.
    push_msg(pack(32'd1, 32'h1, 32'h2, 32'h0, 32'h0));
    exp_q.push_back(32'h0001_0003);
    exp_q.push_back(32'h1);
    expect_beats("pre_reset", 2);
    @(negedge clk);
    check("pre_reset_state", {30'd0, dut_state}, {30'd0, S_PAY1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_msgs  = 16'd0;
    exp_drops = 16'd0;
    @(negedge clk);
    check("midrst_out_ena",  {31'd0, bus.out_enq__ENA}, 32'd0);
    check("midrst_pipe_rdy", {31'd0, bus.pipe_enq__RDY}, 32'd1);
    check("midrst_out_v",    bus.out_enq_v, 32'd0);
    check_counters("midrst");
    tick();
    push_msg(pack(32'd1, 32'h3, 32'h4, 32'h0, 32'h0));
    exp_q.push_back(32'h0001_0003);
    exp_q.push_back(32'h3);
    exp_q.push_back(32'h4);
    expect_beats("post_reset", 3);
    exp_msgs++;
    check_counters("post_reset");

    // 65536 unknown-tag messages stream through at one per cycle; the drop counter wraps.
    pushes = 0;
    cycles = 0;
    bus.pipe_enq_v = pack(32'd9, 32'h0, 32'h0, 32'h0, 32'h0);
    while (pushes < 65536 && cycles < 70000) begin
      bus.pipe_enq__ENA = bus.pipe_enq__RDY;
      @(posedge clk);
      if (bus.pipe_enq__ENA) begin
        pushes++;
        exp_drops++;
      end
      cycles++;
      #1;
    end
    bus.pipe_enq__ENA = 1'b0;
    if (pushes < 65536) fail_now("wrap_stream");
    repeat (3) tick();
    check("wrap_drops_zero", {16'd0, bus.count_drops}, 32'd0);
    check_counters("wrap");
    push_msg(pack(32'd9, 32'h0, 32'h0, 32'h0, 32'h0));
    tick();
    exp_drops++;
    check_counters("wrap_plus1");

    if (exp_q.size() != 0) fail_now("leftover_expected_beats");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
